// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction fetch unit and its skid FIFO.
package ifu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } ifu_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fifo_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_if.sv
// Fetch-to-decode handshake: the fetch unit drives the master side, decode the slave side.
interface ifu_if;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  modport master (
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready
  );

endinterface

// File: rtl/ifu_skid_fifo.sv
// Skid FIFO between the BRAM read port and decode; an entry pushed into an empty FIFO
// is visible at the head in the same cycle so fetch latency stays at two cycles.
module ifu_skid_fifo
  import ifu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  fifo_entry_t       push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [CNT_W-1:0]  count,
  output logic              head_valid,
  output fifo_entry_t       head
);

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             empty;
  logic             wr_en;
  logic             rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty      = (count_reg == '0);
  assign rd_en      = pop && !empty;
  // Push and pop on an empty FIFO: the entry is consumed straight from the input.
  assign wr_en      = push && !(pop && empty);
  assign head_valid = !empty || push;
  assign head       = empty ? push_data : mem[rd_ptr_reg];
  assign count      = count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (rd_en) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_en && !rd_en && !flush && count_reg == CNT_W'(DEPTH)));

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC generation, BRAM fetch with credit-based issue, redirect/flush and program-load mode.
// Optional IFU_PERF_CNT_EN adds saturating fetched/stall performance counters.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ADDR_W    = 10,
  parameter int          BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_en,
  input  logic [31:0]       redirect_pc,
  ifu_if.master             dec,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic [31:0]       imem_rdata
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  ifu_state_t       state_reg;
  ifu_state_t       state_next;
  logic [31:0]      fetch_pc_reg;
  logic [31:0]      fetch_pc_next;
  logic [31:0]      tag_pc_reg;
  logic             inflight_reg;
  logic             issue;
  logic             flush;
  logic             pop;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occupancy;
  logic             fifo_valid;
  fifo_entry_t      fifo_head;
  fifo_entry_t      push_entry;

  // Any redirect or load entry in RUN, and every LOAD cycle, drops queued and in-flight data.
  assign flush = ((state_reg == RUN) && (prog_en || redirect_en)) || (state_reg == LOAD);
  assign pop   = fifo_valid && dec.out_ready;

  // Slots committed after this cycle's pop; issuing is allowed only while a slot is free.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_reg} - {{CNT_W{1'b0}}, pop};

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    issue         = 1'b0;
    unique case (state_reg)
      BOOT: begin
        state_next = prog_en ? LOAD : RUN;
      end
      RUN: begin
        if (prog_en) begin
          state_next = LOAD;
        end else if (redirect_en) begin
          fetch_pc_next = align_pc(redirect_pc);
        end else if (occupancy < (CNT_W + 1)'(BUF_DEPTH)) begin
          issue         = 1'b1;
          fetch_pc_next = fetch_pc_reg + 32'd4;
        end
      end
      LOAD: begin
        fetch_pc_next = RESET_PC;
        if (!prog_en) state_next = BOOT;
      end
      default: begin
        state_next    = BOOT;
        fetch_pc_next = RESET_PC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= BOOT;
      fetch_pc_reg <= RESET_PC;
      tag_pc_reg   <= RESET_PC;
      inflight_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      inflight_reg <= issue;
      if (issue) tag_pc_reg <= fetch_pc_reg;
    end
  end

  assign push_entry = '{pc: tag_pc_reg, instr: imem_rdata};

  ifu_skid_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_skid_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight_reg),
    .push_data  (push_entry),
    .pop        (pop),
    .flush      (flush),
    .count      (fifo_count),
    .head_valid (fifo_valid),
    .head       (fifo_head)
  );

  assign dec.out_valid = fifo_valid;
  assign dec.out_instr = fifo_valid ? fifo_head.instr : NOP_INSTR;
  assign dec.out_pc    = fifo_valid ? fifo_head.pc : 32'h0;

  always_comb begin
    imem_we    = 1'b0;
    imem_wdata = 32'h0;
    imem_addr  = fetch_pc_reg[ADDR_W+1:2];
    if (state_reg == LOAD) begin
      imem_we    = prog_we;
      imem_wdata = prog_data;
      imem_addr  = prog_addr;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_stall_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_reg <= 32'h0;
      perf_stall_reg   <= 32'h0;
    end else if (state_reg != LOAD) begin
      if (pop && (perf_fetched_reg != 32'hFFFF_FFFF))
        perf_fetched_reg <= perf_fetched_reg + 32'd1;
      if (fifo_valid && !dec.out_ready && (perf_stall_reg != 32'hFFFF_FFFF))
        perf_stall_reg <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_stall   = perf_stall_reg;
`endif

endmodule
